maxnet_mem_controller: RTL and testbench
========================================

MAXNET_MEM_CONTROLLER -- requirements
Module: maxnet_mem_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of each neuron activation, held in the low DATA_W bits of a memory word.
REQ-002 SHALL have parameter EPS_SHIFT, default 3: inhibition weight epsilon = 2^-EPS_SHIFT.
REQ-003 SHALL have parameter MAX_ITER, default 15: iteration limit; range 1..15.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request one Maxnet run; sampled only in IDLE.
REQ-007 SHALL have port mem_address, output, 2 bits: word address to the data memory.
REQ-008 SHALL have port mem_writeEn, output, 1 bit: memory write strobe; the memory writes on the rising clock edge.
REQ-009 SHALL have port mem_write_data, output, 32 bits: write word, activation zero-extended from DATA_W bits.
REQ-010 SHALL have port mem_read_data, input, 32 bits: combinational read of mem_address; bits above DATA_W are ignored.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port winner, output, 2 bits: index of the surviving neuron.
REQ-014 SHALL have port winner_valid, output, 1 bit: exactly one neuron is nonzero at completion.
REQ-015 SHALL have port timeout, output, 1 bit: the run stopped at MAX_ITER with more than one neuron nonzero.
REQ-016 SHALL have port iter_count, output, 4 bits: number of ITER cycles executed in the last run.

Function
REQ-017 SHALL use FSM states IDLE, LOAD, CHECK, ITER, STORE and DONE.
REQ-018 SHALL take IDLE to LOAD at the edge where start=1; start is ignored outside IDLE.
REQ-019 SHALL, in LOAD, spend 4 cycles with mem_address = 0,1,2,3, capture x[i] = mem_read_data[DATA_W-1:0] at each edge, then go to CHECK.
REQ-020 SHALL, in CHECK, count nonzero x[i]: go to STORE if count <= 1 or iter_count == MAX_ITER, else go to ITER.
REQ-021 SHALL, in ITER, update all x[i] in one cycle from the pre-update values, then increment iter_count and return to CHECK.
REQ-022 SHALL compute the update as S = sum of x[0..3] at DATA_W+2 bits, inh = (S - x[i]) >> EPS_SHIFT, x[i] <= (x[i] > inh) ? x[i] - inh : 0; there is no wrap or negative value.
REQ-023 SHALL, in STORE, spend 4 cycles with mem_writeEn=1, mem_address = 0..3 and mem_write_data = zero-extended x[address], then go to DONE.
REQ-024 SHALL drive mem_writeEn=0 in every state other than STORE.
REQ-025 SHALL, in DONE, pulse done=1 for one cycle, then go to IDLE.
REQ-026 SHALL latch winner, winner_valid and timeout on entry to STORE and hold them until the next LOAD entry; these three outputs and iter_count clear on LOAD entry.
REQ-027 SHALL set winner to the index of the single nonzero x; winner=0 with winner_valid=0 when zero or several neurons remain nonzero.
REQ-028 SHALL set timeout=1 only when the limit is reached with count > 1; all-zero outcome gives timeout=0.
REQ-029 SHALL make done high in cycle 10+2k after the start-sampling edge, where k is iterations executed.
REQ-030 SHALL drive mem_address=0 in IDLE, CHECK, ITER and DONE.

Reset
REQ-031 SHALL, on reset at any time including mid-LOAD or mid-STORE, immediately force state IDLE, mem_writeEn=0, mem_address=0, mem_write_data=0, busy=0, done=0, winner=0, winner_valid=0, timeout=0, iter_count=0 and all x[i]=0.
REQ-032 SHALL, after reset mid-STORE, leave already-written words as written; no further writes occur.

Verification
REQ-033 Memory {10,4,2,1}, start -> iterations give {10,3,1,0},{10,2,0,0},{10,1,0,0},{10,0,0,0}; k=4, done at cycle 18, memory {10,0,0,0}, winner=0, winner_valid=1, timeout=0, iter_count=4.
REQ-034 Memory {5,5,0,0}, start -> values unchanged each iteration; iter_count=15, timeout=1, winner_valid=0, memory unchanged, done at cycle 40.
REQ-035 Memory {0,0,7,0}, start -> no ITER; iter_count=0, winner=2, winner_valid=1, done at cycle 10.
REQ-036 Memory {0,0,0,0}, start -> iter_count=0, winner_valid=0, timeout=0, done at cycle 10.
REQ-037 Reset asserted during the second STORE cycle -> busy=0 and mem_writeEn=0 immediately; word 0 updated, words 1-3 untouched; start pulsed while busy is ignored.

Source files
------------

// File: rtl/maxnet_mem_controller.sv
// Maxnet winner-take-all engine: loads four activations from memory, iterates
// mutual inhibition until at most one survives or MAX_ITER is hit, writes them back.
module maxnet_mem_controller #(
  parameter int DATA_W    = 16,
  parameter int EPS_SHIFT = 3,
  parameter int MAX_ITER  = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [1:0]  mem_address,
  output logic        mem_writeEn,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner,
  output logic        winner_valid,
  output logic        timeout,
  output logic [3:0]  iter_count
);

  localparam int SUM_W = DATA_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_ITER, S_STORE, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_idx;
  logic [DATA_W-1:0] r_x [4];
  logic [3:0]        r_iter;
  logic [1:0]        r_winner;
  logic              r_winner_valid;
  logic              r_timeout;
  logic [SUM_W-1:0]  w_sum;
  logic [2:0]        w_nz_cnt;
  logic [1:0]        w_nz_idx;
  logic              w_stop;

  // Inhibition by the other three neurons, clamped at zero instead of wrapping.
  function automatic logic [DATA_W-1:0] inhibit(input logic [DATA_W-1:0] x,
                                                input logic [SUM_W-1:0]  sum);
    logic [SUM_W-1:0] inh;
    inh = (sum - SUM_W'(x)) >> EPS_SHIFT;
    return (SUM_W'(x) > inh) ? x - inh[DATA_W-1:0] : '0;
  endfunction

  always_comb begin
    w_sum    = '0;
    w_nz_cnt = '0;
    w_nz_idx = '0;
    for (int i = 0; i < 4; i++) begin
      w_sum = w_sum + SUM_W'(r_x[i]);
      if (r_x[i] != '0) begin
        w_nz_cnt = w_nz_cnt + 3'd1;
        w_nz_idx = 2'(i);
      end
    end
    w_stop = (w_nz_cnt <= 3'd1) || (r_iter == 4'(MAX_ITER));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    mem_writeEn = 1'b0;
    mem_address = 2'd0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        mem_address = r_idx;
        if (r_idx == 2'd3) w_next = S_CHECK;
      end
      S_CHECK: w_next = w_stop ? S_STORE : S_ITER;
      S_ITER:  w_next = S_CHECK;
      S_STORE: begin
        mem_address = r_idx;
        mem_writeEn = 1'b1;
        if (r_idx == 2'd3) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_write_data = mem_writeEn ? 32'(r_x[r_idx]) : 32'd0;
  assign winner         = r_winner;
  assign winner_valid   = r_winner_valid;
  assign timeout        = r_timeout;
  assign iter_count     = r_iter;

  // r_idx wraps 3 -> 0 at the end of LOAD, so STORE starts at word 0 too.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx          <= '0;
      r_iter         <= '0;
      r_winner       <= '0;
      r_winner_valid <= 1'b0;
      r_timeout      <= 1'b0;
      for (int i = 0; i < 4; i++) r_x[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx          <= '0;
            r_iter         <= '0;
            r_winner       <= '0;
            r_winner_valid <= 1'b0;
            r_timeout      <= 1'b0;
          end
        end
        S_LOAD: begin
          r_x[r_idx] <= mem_read_data[DATA_W-1:0];
          r_idx      <= r_idx + 2'd1;
        end
        S_CHECK: begin
          if (w_stop) begin
            r_winner       <= (w_nz_cnt == 3'd1) ? w_nz_idx : 2'd0;
            r_winner_valid <= (w_nz_cnt == 3'd1);
            r_timeout      <= (w_nz_cnt > 3'd1);
            r_idx          <= '0;
          end
        end
        S_ITER: begin
          for (int i = 0; i < 4; i++) r_x[i] <= inhibit(r_x[i], w_sum);
          r_iter <= r_iter + 4'd1;
        end
        S_STORE: r_idx <= r_idx + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_mem_controller.sv
// Randomized bench for maxnet_mem_controller against a plain-arithmetic Maxnet model.
module tb_maxnet_mem_controller;

  localparam int DATA_W    = 16;
  localparam int EPS_SHIFT = 3;
  localparam int MAX_ITER  = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mem_address;
  logic        mem_writeEn;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        busy, done, winner_valid, timeout;
  logic [1:0]  winner;
  logic [3:0]  iter_count;

  logic [31:0] mem  [4];
  logic [31:0] init [4];
  logic        ld_en;

  int total = 0;
  int bad   = 0;
  int ex [4];
  int ek, ewin, ewv, eto;

  maxnet_mem_controller #(.DATA_W(DATA_W), .EPS_SHIFT(EPS_SHIFT), .MAX_ITER(MAX_ITER)) dut (
    .clock(clk), .reset(rst), .start(start),
    .mem_address(mem_address), .mem_writeEn(mem_writeEn),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy), .done(done), .winner(winner), .winner_valid(winner_valid),
    .timeout(timeout), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address];

  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < 4; i++) mem[i] <= init[i];
    end else if (mem_writeEn) begin
      mem[mem_address] <= mem_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: iterate x_i <- max(x_i - (sum of others)/2^eps, 0) while >1 survive.
  task automatic model();
    int xs [4];
    int nx [4];
    int s, nz, k, w;
    for (int i = 0; i < 4; i++) xs[i] = int'(init[i] & 32'h0000_FFFF);
    k = 0;
    forever begin
      nz = 0;
      for (int i = 0; i < 4; i++) if (xs[i] != 0) nz++;
      if (nz <= 1 || k == MAX_ITER) break;
      s = xs[0] + xs[1] + xs[2] + xs[3];
      for (int i = 0; i < 4; i++) begin
        nx[i] = xs[i] - (s - xs[i]) / (2 ** EPS_SHIFT);
        if (nx[i] < 0) nx[i] = 0;
      end
      xs = nx;
      k++;
    end
    w = 0;
    for (int i = 0; i < 4; i++) if (xs[i] != 0) w = i;
    ex   = xs;
    ek   = k;
    ewv  = (nz == 1) ? 1 : 0;
    ewin = (nz == 1) ? w : 0;
    eto  = (nz > 1) ? 1 : 0;
  endtask

  task automatic load_mem(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
    init[0] = a; init[1] = b; init[2] = c; init[3] = d;
    @(negedge clk);
    ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic run_case(input string name);
    int n, got_n;
    model();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    got_n = -1;
    while (got_n < 0 && n < 200) begin
      @(negedge clk);
      n++;
      start = (n == 3);
      if (done) got_n = n;
    end
    start = 1'b0;
    check({name, ".done_cycle"}, 32'(got_n), 32'(10 + 2 * ek));
    check({name, ".iter"},    32'(iter_count),   32'(ek));
    check({name, ".winner"},  32'(winner),       32'(ewin));
    check({name, ".wvalid"},  32'(winner_valid), 32'(ewv));
    check({name, ".timeout"}, 32'(timeout),      32'(eto));
    check({name, ".busy_done"}, 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s.mem%0d", name, i), mem[i], 32'(ex[i]));
    @(negedge clk);
    check({name, ".idle_busy"}, 32'(busy), 32'd0);
    check({name, ".idle_done"}, 32'(done), 32'd0);
    check({name, ".hold_winner"}, 32'(winner), 32'(ewin));
  endtask

  task automatic reset_mid_store();
    int n;
    load_mem(32'hABCD_0004, 32'h1234_000A, 32'h0000_0002, 32'h5555_0001);
    model();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (n = 1; n < 7 + 2 * ek; n++) @(negedge clk);
    @(negedge clk);
    check("rst.pre_we",   32'(mem_writeEn), 32'd1);
    check("rst.pre_addr", 32'(mem_address), 32'd1);
    rst = 1'b1;
    #1;
    check("rst.busy", 32'(busy),           32'd0);
    check("rst.we",   32'(mem_writeEn),    32'd0);
    check("rst.addr", 32'(mem_address),    32'd0);
    check("rst.wd",   mem_write_data,      32'd0);
    check("rst.iter", 32'(iter_count),     32'd0);
    check("rst.wv",   32'(winner_valid),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst.mem0", mem[0], 32'(ex[0]));
    for (int i = 1; i < 4; i++)
      check($sformatf("rst.mem%0d_kept", i), mem[i], init[i]);
    check("rst.idle", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] rand_word(input int mode);
    logic [15:0] v;
    case (mode)
      0:       v = 16'd0;
      1:       v = 16'($urandom_range(1, 40));
      2:       v = 16'($urandom_range(1000, 1100));
      default: v = 16'($urandom_range(1, 65535));
    endcase
    return {16'($urandom()), v};
  endfunction

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ld_en = 1'b0;
    #1;
    check("reset.busy",   32'(busy),           32'd0);
    check("reset.done",   32'(done),           32'd0);
    check("reset.we",     32'(mem_writeEn),    32'd0);
    check("reset.addr",   32'(mem_address),    32'd0);
    check("reset.wd",     mem_write_data,      32'd0);
    check("reset.winner", 32'(winner),         32'd0);
    check("reset.wv",     32'(winner_valid),   32'd0);
    check("reset.to",     32'(timeout),        32'd0);
    check("reset.iter",   32'(iter_count),     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    load_mem(32'd10, 32'd4, 32'd2, 32'd1);
    run_case("c_10_4_2_1");
    load_mem(32'd5, 32'd5, 32'd0, 32'd0);
    run_case("c_5_5");
    load_mem(32'd0, 32'd0, 32'd7, 32'd0);
    run_case("c_single");
    load_mem(32'd0, 32'd0, 32'd0, 32'd0);
    run_case("c_zero");
    load_mem(32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF);
    run_case("c_max");

    reset_mid_store();

    for (int t = 0; t < 24; t++) begin
      load_mem(rand_word($urandom_range(0, 3)), rand_word($urandom_range(0, 3)),
               rand_word($urandom_range(0, 3)), rand_word($urandom_range(0, 3)));
      run_case($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
